// File: rtl/keyboard_decoder_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard decoder.
//  - Scan-code constants for the keys and prefixes the decoder understands.
//  - state_t: decoder FSM states.
package keyboard_decoder_pkg;

  localparam logic [7:0] KEY_LEFT     = 8'h6B;
  localparam logic [7:0] KEY_RIGHT    = 8'h74;
  localparam logic [7:0] KEY_UP       = 8'h75;
  localparam logic [7:0] KEY_DOWN     = 8'h72;
  localparam logic [7:0] KEY_SPACE    = 8'h29;
  localparam logic [7:0] KEY_ENTER    = 8'h5A;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK,
    ST_SKIP
  } state_t;

endpackage

// File: rtl/keyboard_decoder_if.sv
// Byte stream from the PS/2 receiver into the decoder.
//  rx_data  : received scan-code byte
//  rx_valid : one-cycle strobe, rx_data valid
//  rx_error : one-cycle strobe, parity/frame error on the current byte
// master = byte receiver (drives), slave = decoder (samples).
interface keyboard_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  modport master (output rx_data, rx_valid, rx_error);
  modport slave  (input  rx_data, rx_valid, rx_error);
endinterface

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 scan-code decoder producing held-key levels for the movement FSM.
// Tracks make/break and E0-extended prefixes, swallows Pause (E1) sequences and
// falls back to idle on receive errors or a stalled multi-byte code.
// Ports:
//  clk, rst    : clock, synchronous active-high reset
//  rx          : byte stream from the receiver (slave modport)
//  game_over   : level, clears start_game (wins over an Enter make)
//  left/right/up/down : E0 6B / E0 74 / E0 75 / E0 72 held
//  jump        : 29 (space) held
//  start_game  : latched by Enter make, cleared only by game_over
module keyboard_decoder
  import keyboard_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_600_000,
  parameter int SKIP_BYTES     = 7
) (
  input  logic                clk,
  input  logic                rst,
  keyboard_decoder_if.slave   rx,
  input  logic                game_over,
  output logic                left,
  output logic                right,
  output logic                up,
  output logic                down,
  output logic                jump,
  output logic                start_game
);

  localparam int         TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SKIP_INIT = 3'(SKIP_BYTES);

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [2:0]    skip_cnt;
  logic          byte_ok;
  logic          timeout;

  assign byte_ok = rx.rx_valid && !rx.rx_error;
  // A byte arriving on the limit cycle still counts; timeout only fires when idle on the bus.
  assign timeout = (state != ST_IDLE) && !rx.rx_valid && (tcnt == TLIM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (rx.rx_valid && rx.rx_error) begin
      state_nxt = ST_IDLE;
    end else if (byte_ok) begin
      unique case (state)
        ST_IDLE: begin
          if      (rx.rx_data == PREFIX_EXT)   state_nxt = ST_EXT;
          else if (rx.rx_data == PREFIX_BREAK) state_nxt = ST_BREAK;
          else if (rx.rx_data == PREFIX_PAUSE) state_nxt = ST_SKIP;
        end
        ST_EXT:       state_nxt = (rx.rx_data == PREFIX_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        ST_BREAK:     state_nxt = ST_IDLE;
        ST_EXT_BREAK: state_nxt = ST_IDLE;
        ST_SKIP:      if (skip_cnt <= 3'd1) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  // Outputs and counters (all registered)
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt       <= '0;
      skip_cnt   <= '0;
      left       <= 1'b0;
      right      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      jump       <= 1'b0;
      start_game <= 1'b0;
    end else begin
      if (state == ST_IDLE || rx.rx_valid || tcnt == TLIM) tcnt <= '0;
      else                                                 tcnt <= tcnt + 1'b1;

      if (byte_ok && state == ST_IDLE && rx.rx_data == PREFIX_PAUSE)
        skip_cnt <= SKIP_INIT;
      else if (byte_ok && state == ST_SKIP && skip_cnt != 3'd0)
        skip_cnt <= skip_cnt - 3'd1;

      // Makes set, breaks clear; repeated makes are naturally idempotent.
      if (byte_ok) begin
        unique case (state)
          ST_IDLE:  if (rx.rx_data == KEY_SPACE) jump <= 1'b1;
          ST_BREAK: if (rx.rx_data == KEY_SPACE) jump <= 1'b0;
          ST_EXT: begin
            if (rx.rx_data == KEY_LEFT)  left  <= 1'b1;
            if (rx.rx_data == KEY_RIGHT) right <= 1'b1;
            if (rx.rx_data == KEY_UP)    up    <= 1'b1;
            if (rx.rx_data == KEY_DOWN)  down  <= 1'b1;
          end
          ST_EXT_BREAK: begin
            if (rx.rx_data == KEY_LEFT)  left  <= 1'b0;
            if (rx.rx_data == KEY_RIGHT) right <= 1'b0;
            if (rx.rx_data == KEY_UP)    up    <= 1'b0;
            if (rx.rx_data == KEY_DOWN)  down  <= 1'b0;
          end
          default: ;
        endcase
      end

      // Enter break is deliberately ignored: only game_over ends the game.
      if (game_over)
        start_game <= 1'b0;
      else if (byte_ok && state == ST_IDLE && rx.rx_data == KEY_ENTER)
        start_game <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed bench for keyboard_decoder. Output vector order:
// {left, right, up, down, jump, start_game}.
module tb_keyboard_decoder;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst;
  logic game_over;
  logic left, right, up, down, jump, start_game;
  int   total = 0;
  int   bad   = 0;

  keyboard_decoder_if kif ();

  keyboard_decoder #(.TIMEOUT_CYCLES(TO), .SKIP_BYTES(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (kif),
    .game_over  (game_over),
    .left       (left),
    .right      (right),
    .up         (up),
    .down       (down),
    .jump       (jump),
    .start_game (start_game)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {left, right, up, down, jump, start_game};
  endfunction

  // One strobe; returns on the negedge after the sampling edge.
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    @(negedge clk);
    kif.rx_data  = b;
    kif.rx_valid = 1'b1;
    kif.rx_error = err;
    @(negedge clk);
    kif.rx_valid = 1'b0;
    kif.rx_error = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_arrows();
    logic [7:0] codes [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
    logic [5:0] mk    [4] = '{6'b100000, 6'b110000, 6'b111000, 6'b111100};
    logic [5:0] brk   [4] = '{6'b011100, 6'b001100, 6'b000100, 6'b000000};
    send(8'hE0);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL ext_prefix_only got=%b exp=%b", outs(), 6'b000000);
    end
    send(codes[0]);
    total++;
    if (outs() !== mk[0]) begin
      bad++; $display("FAIL arrow_make_0 got=%b exp=%b", outs(), mk[0]);
    end
    for (int i = 1; i < 4; i++) begin
      send(8'hE0); send(codes[i]);
      total++;
      if (outs() !== mk[i]) begin
        bad++; $display("FAIL arrow_make_%0d got=%b exp=%b", i, outs(), mk[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(8'hE0); send(8'hF0); send(codes[i]);
      total++;
      if (outs() !== brk[i]) begin
        bad++; $display("FAIL arrow_break_%0d got=%b exp=%b", i, outs(), brk[i]);
      end
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 3; i++) begin
      send(8'h29);
      total++;
      if (outs() !== 6'b000010) begin
        bad++; $display("FAIL jump_make_%0d got=%b exp=%b", i, outs(), 6'b000010);
      end
    end
    send(8'hF0);
    total++;
    if (outs() !== 6'b000010) begin
      bad++; $display("FAIL jump_break_prefix got=%b exp=%b", outs(), 6'b000010);
    end
    send(8'h29);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL jump_break got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_start();
    send(8'h5A);
    total++;
    if (outs() !== 6'b000001) begin
      bad++; $display("FAIL start_make got=%b exp=%b", outs(), 6'b000001);
    end
    send(8'hF0); send(8'h5A);
    total++;
    if (outs() !== 6'b000001) begin
      bad++; $display("FAIL start_break_held got=%b exp=%b", outs(), 6'b000001);
    end
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL game_over_clear got=%b exp=%b", outs(), 6'b000000);
    end
    @(negedge clk) game_over = 1'b1;
    send(8'h5A);
    game_over = 1'b0;
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL game_over_wins got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_timeout();
    // Within the window the arrow still decodes.
    send(8'hE0);
    repeat (10) @(negedge clk);
    send(8'h6B);
    total++;
    if (outs() !== 6'b100000) begin
      bad++; $display("FAIL timeout_in_window got=%b exp=%b", outs(), 6'b100000);
    end
    send(8'hE0); send(8'hF0); send(8'h6B);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL timeout_release got=%b exp=%b", outs(), 6'b000000);
    end
    // Past the window the prefix is dropped and 6B alone means nothing.
    send(8'hE0);
    repeat (TO + 2) @(negedge clk);
    send(8'h6B);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL timeout_abort got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq[i]);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL pause_quiet got=%b exp=%b", outs(), 6'b000000);
    end
    send(8'h29);
    total++;
    if (outs() !== 6'b000010) begin
      bad++; $display("FAIL pause_then_jump got=%b exp=%b", outs(), 6'b000010);
    end
    send(8'hF0); send(8'h29);
    // Exactly seven bytes are swallowed, whatever they are.
    send(8'hE1);
    for (int i = 0; i < 7; i++) begin
      send(8'h29);
      total++;
      if (outs() !== 6'b000000) begin
        bad++; $display("FAIL skip_byte_%0d got=%b exp=%b", i, outs(), 6'b000000);
      end
    end
    send(8'h29);
    total++;
    if (outs() !== 6'b000010) begin
      bad++; $display("FAIL skip_end got=%b exp=%b", outs(), 6'b000010);
    end
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_error();
    send(8'hF0, 1'b1);
    send(8'h29);
    total++;
    if (outs() !== 6'b000010) begin
      bad++; $display("FAIL error_drops_break got=%b exp=%b", outs(), 6'b000010);
    end
    // Errored break byte inside a sequence leaves jump held.
    send(8'hF0); send(8'h29, 1'b1);
    total++;
    if (outs() !== 6'b000010) begin
      bad++; $display("FAIL error_keeps_level got=%b exp=%b", outs(), 6'b000010);
    end
    send(8'hF0); send(8'h29);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL error_recover got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    kif.rx_data = 8'hE0; kif.rx_valid = 1'b1;
    @(negedge clk);
    kif.rx_data = 8'h75;
    @(negedge clk);
    kif.rx_data = 8'h29;
    @(negedge clk);
    kif.rx_valid = 1'b0;
    total++;
    if (outs() !== 6'b001010) begin
      bad++; $display("FAIL back_to_back got=%b exp=%b", outs(), 6'b001010);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h5A); send(8'hE0); send(8'h6B); send(8'hE0);
    total++;
    if (outs() !== 6'b101011) begin
      bad++; $display("FAIL pre_reset got=%b exp=%b", outs(), 6'b101011);
    end
    pulse_reset();
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b", outs(), 6'b000000);
    end
    send(8'h6B);
    total++;
    if (outs() !== 6'b000000) begin
      bad++; $display("FAIL reset_to_idle got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  initial begin
    rst          = 1'b1;
    game_over    = 1'b0;
    kif.rx_data  = 8'h00;
    kif.rx_valid = 1'b0;
    kif.rx_error = 1'b0;
    test_reset();
    test_arrows();
    test_jump();
    test_start();
    test_timeout();
    test_pause();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
